// File: rtl/tmu_rrq_arb_pkg.sv
// Shared constants and types for the TMU read-request arbiter.
// No ports; the arbiter, its interface and the bench import these defaults.
package tmu_pkg;
    localparam int TMU_RRQ_N_REQ   = 4;
    localparam int TMU_RRQ_ADDR_W  = 20;
    localparam int TMU_RRQ_CREDITS = 16;
    localparam int TMU_RRQ_SRC_W   = $clog2(TMU_RRQ_N_REQ);
    localparam int TMU_RRQ_CRED_W  = $clog2(TMU_RRQ_CREDITS + 1);

    typedef logic [TMU_RRQ_SRC_W-1:0] tmu_rrq_src_t;

    typedef struct packed {
        logic [TMU_RRQ_ADDR_W-1:0] addr;
        tmu_rrq_src_t              src;
    } tmu_rrq_req_t;
endpackage

// File: rtl/tmu_rrq_arb_if.sv
// Request/issue/response bundle between the TMU requesters, the arbiter and MRI.
// slave: arbiter side (takes requests, drives rrq); master: sources and MRI model.
interface tmu_rrq_arb_if
    import tmu_pkg::*;
#(
    parameter int N_REQ  = TMU_RRQ_N_REQ,
    parameter int ADDR_W = TMU_RRQ_ADDR_W
);
    localparam int SW = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        req_ready;
    logic                    rrq_valid;
    logic [ADDR_W-1:0]       rrq_addr;
    logic [SW-1:0]           rrq_src;
    logic                    rrq_ready;
    logic                    rrs_valid;

    modport master (
        output req_valid, req_addr, rrq_ready, rrs_valid,
        input  req_ready, rrq_valid, rrq_addr, rrq_src
    );

    modport slave (
        input  req_valid, req_addr, rrq_ready, rrs_valid,
        output req_ready, rrq_valid, rrq_addr, rrq_src
    );
endinterface

// File: rtl/tmu_rrq_arb_rr_arb.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
// Ports: req (vector), ptr (start index) -> gnt (one-hot), idx (encoded), any.
module rr_arb #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end
endmodule

// File: rtl/tmu_rrq_arb.sv
// Round-robin arbiter + MRI credit manager for the TMU rrq port.
// Ports: clk, rst (sync high), cfg_enable, bus (slave), credits_avail, err_credit_ovf.
module tmu_rrq_arb
    import tmu_pkg::*;
#(
    parameter int N_REQ   = TMU_RRQ_N_REQ,
    parameter int ADDR_W  = TMU_RRQ_ADDR_W,
    parameter int CREDITS = TMU_RRQ_CREDITS,
    parameter int SW      = $clog2(N_REQ),
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_enable,
    tmu_rrq_arb_if.slave  bus,
    output logic [CW-1:0] credits_avail,
    output logic          err_credit_ovf
);
    logic [SW-1:0]    rr_ptr;
    logic [N_REQ-1:0] gnt;
    logic [SW-1:0]    win;
    logic             any;
    logic             free;
    logic             grant;

    rr_arb #(.N(N_REQ), .IW(SW)) u_rr (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (win),
        .any (any)
    );

    // The output slot frees up when empty or drained this same cycle,
    // which is what allows one issue per cycle under full throughput.
    assign free  = !bus.rrq_valid || bus.rrq_ready;
    assign grant = !rst && free && cfg_enable
                 && (credits_avail != '0) && any;

    assign bus.req_ready = grant ? gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rrq_valid <= 1'b0;
            bus.rrq_addr  <= '0;
            bus.rrq_src   <= '0;
            rr_ptr        <= '0;
        end else if (grant) begin
            bus.rrq_valid <= 1'b1;
            bus.rrq_addr  <= bus.req_addr[win*ADDR_W +: ADDR_W];
            bus.rrq_src   <= win;
            rr_ptr        <= (win == SW'(N_REQ - 1)) ? '0 : win + SW'(1);
        end else if (bus.rrq_ready) begin
            bus.rrq_valid <= 1'b0;
        end
    end

    // A return in the same cycle as a grant nets out; a return with
    // nothing outstanding is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_avail  <= CW'(CREDITS);
            err_credit_ovf <= 1'b0;
        end else begin
            unique case ({grant, bus.rrs_valid})
                2'b10: credits_avail <= credits_avail - CW'(1);
                2'b01: begin
                    if (credits_avail == CW'(CREDITS))
                        err_credit_ovf <= 1'b1;
                    else
                        credits_avail <= credits_avail + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tmu_rrq_arb.sv
// Bench for tmu_rrq_arb: directed scenarios plus random traffic
// against a transaction-level model (issue queue + credit arithmetic).
module tb_tmu_rrq_arb;
    import tmu_pkg::*;

    localparam int N  = TMU_RRQ_N_REQ;
    localparam int AW = TMU_RRQ_ADDR_W;
    localparam int CR = TMU_RRQ_CREDITS;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic [TMU_RRQ_CRED_W-1:0] credits_avail;
    logic err_credit_ovf;

    tmu_rrq_arb_if #(.N_REQ(N), .ADDR_W(AW)) io ();

    tmu_rrq_arb dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_enable     (en),
        .bus            (io),
        .credits_avail  (credits_avail),
        .err_credit_ovf (err_credit_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    tmu_rrq_req_t sb[$];
    tmu_rrq_src_t fired[$];
    int  m_cred;
    int  m_ptr;
    bit  m_err;
    int  n_grant;
    int  last_w;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_addr();
        for (int i = 0; i < N; i++)
            io.req_addr[i*AW +: AW] = AW'($urandom);
    endtask

    // Called with inputs already applied just after a rising edge.
    task automatic cyc();
        bit free;
        int w;
        int c;
        logic [N-1:0] exp_rdy;
        tmu_rrq_req_t e;
        #1;
        free = (sb.size() == 0) || io.rrq_ready;
        w = -1;
        if (!rst && free && en && m_cred > 0) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (w < 0 && io.req_valid[c]) w = c;
            end
        end
        exp_rdy = (w >= 0) ? N'(1 << w) : '0;
        check("req_ready", 32'(io.req_ready), 32'(exp_rdy));
        check("rrq_valid", 32'(io.rrq_valid), 32'(sb.size() != 0));
        check("credits", 32'(credits_avail), 32'(m_cred));
        check("err_ovf", 32'(err_credit_ovf), 32'(m_err));
        if (sb.size() != 0) begin
            check("rrq_addr", 32'(io.rrq_addr), 32'(sb[0].addr));
            check("rrq_src", 32'(io.rrq_src), 32'(sb[0].src));
        end
        if (rst) begin
            sb.delete();
            m_cred = CR;
            m_ptr  = 0;
            m_err  = 0;
        end else begin
            if (sb.size() != 0 && io.rrq_ready) begin
                fired.push_back(sb[0].src);
                void'(sb.pop_front());
            end
            if (w >= 0) begin
                e.addr = io.req_addr[w*AW +: AW];
                e.src  = tmu_rrq_src_t'(w);
                sb.push_back(e);
                m_ptr  = (w + 1) % N;
                n_grant++;
                last_w = w;
            end
            m_cred = m_cred - ((w >= 0) ? 1 : 0) + (io.rrs_valid ? 1 : 0);
            if (m_cred > CR) begin
                m_cred = CR;
                m_err  = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_addr", 32'(io.rrq_addr), 32'd0);
        check("rst_src", 32'(io.rrq_src), 32'd0);
        check("rst_cred", 32'(credits_avail), 32'(CR));
        n_grant = 0;
        fired.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        logic [AW-1:0] held;
        rst          = 1'b1;
        en           = 1'b0;
        io.req_valid = '0;
        io.req_addr  = '0;
        io.rrq_ready = 1'b0;
        io.rrs_valid = 1'b0;
        m_cred = CR; m_ptr = 0; m_err = 0; n_grant = 0; last_w = -1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Full rotation at one issue per cycle, credit returned next cycle.
        en = 1'b1;
        io.req_valid = '1;
        io.rrq_ready = 1'b1;
        repeat (12) begin
            rand_addr();
            io.rrs_valid = (m_cred < CR);
            cyc();
        end
        check("t1_fires", fired.size(), 32'd11);
        foreach (fired[i]) check("t1_src_seq", 32'(fired[i]), 32'(i % N));
        check("t1_cred", 32'(credits_avail), 32'(CR - 1));

        // Credit exhaustion and single-credit refill.
        io.rrs_valid = 1'b0;
        do_reset();
        io.req_valid = 4'b0001;
        repeat (CR + 4) begin rand_addr(); cyc(); end
        check("t2_grants", n_grant, CR);
        check("t2_cred0", 32'(credits_avail), 32'd0);
        io.rrs_valid = 1'b1;
        cyc();
        io.rrs_valid = 1'b0;
        check("t2_same_cyc", n_grant, CR);
        cyc();
        check("t2_refill", n_grant, CR + 1);
        repeat (3) cyc();
        check("t2_only_one", n_grant, CR + 1);

        // Backpressure: held entry stays put, then accept-and-reload.
        do_reset();
        io.req_valid = '1;
        io.rrq_ready = 1'b0;
        rand_addr();
        cyc();
        held = io.rrq_addr;
        repeat (5) begin rand_addr(); cyc(); end
        check("t3_held_addr", 32'(io.rrq_addr), 32'(held));
        check("t3_stalled", n_grant, 32'd1);
        io.rrq_ready = 1'b1;
        cyc();
        check("t3_reload", n_grant, 32'd2);

        // Wrap-around search.
        do_reset();
        io.req_valid = 4'b0100;
        cyc();
        cyc();
        check("t4_wrap", last_w, 32'd2);
        check("t4_ptr", m_ptr, 32'd3);
        io.req_valid = 4'b1010;
        cyc();
        check("t4_g3", last_w, 32'd3);
        cyc();
        check("t4_g1", last_w, 32'd1);

        // Overflow at full, then net-zero grant+return at 8.
        io.req_valid = '0;
        do_reset();
        io.rrs_valid = 1'b1;
        cyc();
        io.rrs_valid = 1'b0;
        cyc();
        check("t5_err", 32'(err_credit_ovf), 32'd1);
        check("t5_full", 32'(credits_avail), 32'(CR));
        io.req_valid = 4'b0001;
        repeat (8) cyc();
        io.rrs_valid = 1'b1;
        cyc();
        io.rrs_valid = 1'b0;
        io.req_valid = '0;
        cyc();
        check("t5_net0", 32'(credits_avail), 32'd8);
        check("t5_sticky", 32'(err_credit_ovf), 32'd1);

        // Disable drains the held entry without a new grant; reset mid-stream.
        do_reset();
        io.req_valid = '1;
        io.rrq_ready = 1'b0;
        cyc();
        en = 1'b0;
        io.rrq_ready = 1'b1;
        cyc();
        cyc();
        check("t6_no_grant", n_grant, 32'd1);
        check("t6_drained", 32'(io.rrq_valid), 32'd0);
        en = 1'b1;
        repeat (6) begin
            rand_addr();
            io.rrs_valid = (m_cred < CR) && $urandom_range(0, 1) == 1;
            cyc();
        end
        io.rrs_valid = 1'b0;
        do_reset();
        check("t6_rst_valid", 32'(io.rrq_valid), 32'd0);

        // Random traffic.
        repeat (400) begin
            rst          = ($urandom_range(0, 99) == 0);
            en           = ($urandom_range(0, 9) != 0);
            io.req_valid = N'($urandom);
            io.rrq_ready = ($urandom_range(0, 3) != 0);
            io.rrs_valid = (m_cred < CR) && ($urandom_range(0, 1) == 1);
            rand_addr();
            cyc();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
